// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
// master: fetch_unit view; slave: memory/decode/branch-unit view.
interface fetch_unit_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [ILEN-1:0] id_instr;
    logic            id_ready;
    logic [CW-1:0]   fifo_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_pc, id_instr,
        input  id_ready,
        output fifo_count
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_pc, id_instr,
        output id_ready,
        input  fifo_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Credit-limited instruction fetch stage with PC-tagged prefetch FIFO.
// Ports: clk, reset (sync, active-high), bus (fetch_unit_if.master).
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4,
    parameter int              PC_STEP  = 4
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t state, state_nx;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_next;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] tag_q [DEPTH];
    logic [AW-1:0]   tag_wr, tag_rd;

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [ILEN-1:0] instr_q [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;

    logic          redir;
    logic          req_valid;
    logic          fire;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [CW:0]   inflight;

    assign redir = bus.redirect_valid;

    // A response with nothing outstanding is a protocol error; drop it.
    assign rsp_ok    = bus.imem_rsp_valid && (outstanding != '0);
    assign fire      = req_valid && bus.imem_req_ready;
    assign push      = !reset && !redir && rsp_ok && (state == FETCH);
    assign pop       = bus.id_valid && bus.id_ready;
    assign drop_next = outstanding - CW'(rsp_ok);

    // Every slot is reserved at request time, so a response always fits.
    assign inflight  = {1'b0, outstanding} + {1'b0, count};
    assign credit_ok = inflight < CREDITS;

    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (redir)
            state_nx = (drop_next != '0) ? DRAIN : FETCH;
        else if (state == DRAIN && rsp_ok && drop_cnt == CW'(1))
            state_nx = FETCH;
    end

    always_comb begin
        req_valid = 1'b0;
        if (!reset && !redir && state == FETCH && credit_ok)
            req_valid = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redir) begin
            // Responses still in flight belong to the old path.
            fetch_pc    <= bus.redirect_pc;
            outstanding <= drop_next;
            drop_cnt    <= drop_next;
            count       <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                tag_wr   <= tag_wr + AW'(1);
            end
            outstanding <= outstanding + CW'(fire) - CW'(rsp_ok);
            if (state == DRAIN && rsp_ok)
                drop_cnt <= drop_cnt - CW'(1);
            if (push) begin
                tag_rd <= tag_rd + AW'(1);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            tag_q[tag_wr] <= fetch_pc;
        if (push) begin
            pc_q[wr_ptr]    <= tag_q[tag_rd];
            instr_q[wr_ptr] <= bus.imem_rsp_data;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.id_valid       = !reset && !redir && (count != '0);
    assign bus.id_pc          = pc_q[rd_ptr];
    assign bus.id_instr       = instr_q[rd_ptr];
    assign bus.fifo_count     = reset ? '0 : count;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model plus stream scoreboard.
// Ports: none; drives fetch_unit_if slave side and checks every cycle.
module tb_fetch_unit;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

    fetch_unit #(
        .XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RPC),
        .DEPTH(DEPTH), .PC_STEP(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        bit          ghost;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] fire_log[$];
    logic [31:0] pop_log[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int epoch = 0;
    int mcount = 0;
    logic [31:0] exp_req_pc = RPC;
    logic [31:0] exp_id_pc  = RPC;

    bit d_reset = 1, d_redir = 0, d_id_ready = 0, d_req_ready = 1;
    bit rand_id = 0, rand_req = 0;
    logic [31:0] d_redir_pc = '0;
    int lat_lo = 1, lat_hi = 1;

    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [2:0]  s_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic int n_cur();
        int n = 0;
        foreach (mq[i]) if (!mq[i].ghost && mq[i].epoch == epoch) n++;
        return n;
    endfunction

    function automatic int n_old();
        int n = 0;
        foreach (mq[i]) if (!mq[i].ghost && mq[i].epoch != epoch) n++;
        return n;
    endfunction

    function automatic int n_ghost();
        int n = 0;
        foreach (mq[i]) if (mq[i].ghost) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare against the model, advance the model.
    task automatic step();
        bit    rsp, fire, exp_rv, exp_iv;
        int    dl;
        mreq_t e;
        @(negedge clk);
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(mq[0].addr) : 32'h0;
        reset              = d_reset;
        bus.redirect_valid = d_redir;
        bus.redirect_pc    = d_redir_pc;
        bus.id_ready = rand_id ? 1'($urandom_range(0, 1)) : d_id_ready;
        if (n_ghost() > 0)
            bus.imem_req_ready = 1'b0;
        else
            bus.imem_req_ready = rand_req ? 1'($urandom_range(0, 1)) : d_req_ready;
        #1;
        exp_rv = !d_reset && !d_redir && n_old() == 0 &&
                 (n_cur() + mcount < DEPTH);
        exp_iv = !d_reset && !d_redir && mcount > 0;
        chk("req_valid", bus.imem_req_valid, exp_rv);
        chk("id_valid", bus.id_valid, exp_iv);
        chk("fifo_count", bus.fifo_count, d_reset ? 0 : mcount);
        if (exp_rv) chk("req_addr", bus.imem_req_addr, exp_req_pc);
        if (exp_iv) begin
            chk("id_pc", bus.id_pc, exp_id_pc);
            chk("id_instr", bus.id_instr, mem_word(exp_id_pc));
        end
        s_rv = bus.imem_req_valid;  s_addr  = bus.imem_req_addr;
        s_iv = bus.id_valid;        s_pc    = bus.id_pc;
        s_instr = bus.id_instr;     s_cnt   = bus.fifo_count;

        if (rsp) begin
            e = mq.pop_front();
            if (!d_reset && !d_redir && !e.ghost && e.epoch == epoch)
                mcount++;
        end
        if (exp_iv && bus.id_ready) begin
            pop_log.push_back(exp_id_pc);
            mcount--;
            exp_id_pc += 32'd4;
        end
        fire = bus.imem_req_valid && bus.imem_req_ready && !d_reset;
        if (fire) begin
            dl = cyc + $urandom_range(lat_lo, lat_hi);
            if (mq.size() > 0 && mq[$].due >= dl) dl = mq[$].due + 1;
            mq.push_back('{bus.imem_req_addr, epoch, 1'b0, dl});
            fire_log.push_back(bus.imem_req_addr);
            exp_req_pc += 32'd4;
        end
        if (d_redir) begin
            mcount = 0;
            epoch++;
            exp_req_pc = d_redir_pc;
            exp_id_pc  = d_redir_pc;
        end
        if (d_reset) begin
            foreach (mq[i]) mq[i].ghost = 1'b1;
            mcount = 0;
            epoch++;
            exp_req_pc = RPC;
            exp_id_pc  = RPC;
        end
        cyc++;
    endtask

    initial begin
        logic [31:0] t1_exp [4];
        bit ok;
        t1_exp = '{32'h100, 32'h104, 32'h108, 32'h10C};
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;

        repeat (2) step();
        d_reset = 0;

        // 1: fill with decode stalled
        fire_log.delete();
        repeat (8) step();
        chk("t1_nfire", fire_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < fire_log.size()) chk("t1_addr", fire_log[i], t1_exp[i]);
        chk("t1_cnt", s_cnt, 4);
        chk("t1_pc", s_pc, 32'h100);
        chk("t1_instr", s_instr, 32'hDEAD_0100);
        chk("t1_rv", s_rv, 0);

        // 2: streaming, one per cycle
        d_id_ready = 1;
        pop_log.delete();
        repeat (12) step();
        chk("t2_npop", pop_log.size(), 12);
        if (pop_log.size() == 12) begin
            chk("t2_first", pop_log[0], 32'h100);
            chk("t2_last", pop_log[11], 32'h12C);
        end

        // 3: redirect with two in flight
        lat_lo = 2; lat_hi = 2;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (n_cur() == 2) ok = 1; else step();
        end
        chk("t3_wait", ok, 1);
        d_redir = 1; d_redir_pc = 32'h200;
        step();
        d_redir = 0;
        fire_log.delete(); pop_log.delete();
        step();
        chk("t3_cnt", s_cnt, 0);
        for (int i = 0; i < 20 && pop_log.size() == 0; i++) step();
        chk("t3_npop", pop_log.size() > 0, 1);
        if (pop_log.size() > 0) chk("t3_pc", pop_log[0], 32'h200);
        if (fire_log.size() > 0) chk("t3_fire", fire_log[0], 32'h200);

        // 3b: second redirect while draining
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (n_cur() == 2) ok = 1; else step();
        end
        chk("t3b_wait", ok, 1);
        d_redir = 1; d_redir_pc = 32'h400;
        step();
        d_redir_pc = 32'h500;
        step();
        d_redir = 0;
        pop_log.delete();
        for (int i = 0; i < 20 && pop_log.size() == 0; i++) step();
        chk("t3b_npop", pop_log.size() > 0, 1);
        if (pop_log.size() > 0) chk("t3b_pc", pop_log[0], 32'h500);

        // 4: random stalls, latencies and redirects
        rand_id = 1; rand_req = 1; lat_lo = 1; lat_hi = 3;
        pop_log.delete();
        for (int i = 0; i < 300; i++) begin
            d_redir = ($urandom_range(0, 49) == 0);
            d_redir_pc = 32'h2000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            step();
        end
        d_redir = 0;
        chk("t4_progress", pop_log.size() > 20, 1);

        // 5: memory back-pressure
        rand_id = 0; rand_req = 0; lat_lo = 1; lat_hi = 1;
        d_id_ready = 1; d_req_ready = 0;
        d_redir = 1; d_redir_pc = 32'h600;
        step();
        d_redir = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (n_old() == 0) ok = 1; else step();
        end
        chk("t5_drain", ok, 1);
        fire_log.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_rv", s_rv, 1);
            chk("t5_addr", s_addr, 32'h600);
        end
        chk("t5_nofire", fire_log.size(), 0);
        d_req_ready = 1;
        step();
        step();
        chk("t5_next", s_addr, 32'h604);

        // 6: reset with requests in flight and FIFO occupied
        lat_lo = 3; lat_hi = 3; d_id_ready = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mcount >= 1 && n_cur() >= 2) ok = 1; else step();
        end
        chk("t6_wait", ok, 1);
        d_reset = 1;
        step();
        d_reset = 0;
        fire_log.delete();
        step();
        chk("t6_iv", s_iv, 0);
        chk("t6_cnt", s_cnt, 0);
        chk("t6_rv", s_rv, 1);
        chk("t6_addr", s_addr, 32'h100);
        repeat (10) step();
        chk("t6_nfire", fire_log.size() > 0, 1);
        if (fire_log.size() > 0) chk("t6_fire", fire_log[0], 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
